draw_sequencer: RTL and testbench
=================================

# draw_sequencer

Frame-level draw scheduler that sits directly downstream of the per-object sprite drawers (enemy and player draw blocks) and upstream of the VGA adapter. On each frame tick it grants exactly one drawer at a time, in ascending index order, skipping disabled objects. It forwards the granted drawer's pixel coordinates and colour to the VGA adapter with a plot strobe, and reports frame completion to the game FSM.

## Interface
- `NUM_SRC`, default 5: number of drawer sources (1–8).
- `TIMEOUT`, default 64: watchdog limit in cycles per source grant (only with watchdog compiled in).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse requesting a new frame's draw pass.
- `src_enable`  in  NUM_SRC  per-object enable mask (alive objects); sampled only on an accepted `frame_tick`.
- `src_done`  in  NUM_SRC  drawer done flags. Source i's flag is high for the cycle its last pixel is on its outputs.
- `src_x`  in  8*NUM_SRC  packed drawer x outputs; source i occupies bits [8i+7:8i].
- `src_y`  in  7*NUM_SRC  packed drawer y outputs; source i occupies bits [7i+6:7i].
- `src_colour`  in  3*NUM_SRC  packed drawer colours; source i occupies bits [3i+2:3i].
- `draw_req`  out  NUM_SRC  one-hot (or zero) grant; drives the drawers' draw inputs.
- `vga_x`  out  8  pixel x to the VGA adapter.
- `vga_y`  out  7  pixel y to the VGA adapter.
- `vga_colour`  out  3  pixel colour to the VGA adapter.
- `plot`  out  1  VGA write enable.
- `busy`  out  1  high while a pass is in progress.
- `frame_done`  out  1  one-cycle pulse at the end of a pass.
- `frame_overrun`  out  1  sticky flag: a `frame_tick` arrived while `busy`.
- `timeout_err`  out  1  sticky flag: the watchdog fired.

## Operation
- States are IDLE, DRAW, and DONE. Registers are `state`, `cur` (index), `mask` (latched enable), `first` (first-cycle-of-grant flag), and the watchdog counter.
- IDLE:
  - On `frame_tick`, latch `mask <= src_enable`.
  - If the mask is nonzero, set `cur` to its lowest set bit, set `first`=1, and go to DRAW.
  - If the mask is zero, go to DONE.
- DRAW:
  - `draw_req[cur]`=1 and all other bits are 0.
  - `first` clears after the first cycle of each grant.
  - `plot` = !`first`.
  - When `src_done[cur]`=1 and `first`=0, that cycle is still plotted. Next cycle: move `cur` to the next set mask bit above `cur` with `first`=1, or go to DONE if none.
  - `src_done` of non-granted sources is ignored. A `src_done[cur]` seen while `first`=1 (stale flag) is ignored.
- DONE: `frame_done`=1 for one cycle, then return to IDLE.
- Output mux:
  - When `plot`=1, `vga_x/vga_y/vga_colour` are the `cur` slices of `src_x/src_y/src_colour`, selected combinationally.
  - When `plot`=0, they are 0.
- `busy` = (state != IDLE).
- A `frame_tick` in DRAW or DONE is dropped and sets `frame_overrun`=1.
- Reset values: `draw_req`=0, `plot`=0, `vga_*`=0, `busy`=0, `frame_done`=0, `frame_overrun`=0, `timeout_err`=0, state=IDLE.
- Reset mid-pass: grant is removed in the next cycle and no `frame_done` is issued.

## Timing
- `frame_tick` sampled at cycle T → `draw_req` is high from T+1.
- With a drawer of N pixels (registered outputs, done coincident with last pixel):
  - `plot` is high T+2..T+N+1.
  - `src_done` is seen at T+N+1.
  - The next grant, or DONE, is at T+N+2.
- Each enabled source costs N+1 cycles.
- `frame_done` is high at T+1+k(N+1) for k enabled sources, and at T+1 for an empty mask.
- `busy` falls in the cycle after `frame_done`.
- Latency from the mux to the VGA outputs is 0 cycles.

## Configuration
- Macro `DRAW_SEQ_WATCHDOG_EN`.
- Defined:
  - A counter resets on each grant and increments each DRAW cycle.
  - When it reaches `TIMEOUT` without `src_done[cur]`, the grant advances exactly as if done were seen, but that cycle is not plotted.
  - `timeout_err` is set and stays sticky until reset.
- Undefined: no counter exists, DRAW waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- Reset, then tick with `src_enable`=5'b00001 and a 20-pixel drawer model → `draw_req`=00001 at T+1, 20 `plot` pulses at T+2..T+21, `frame_done` at T+22, `busy` low at T+23.
- Mask 5'b10100 → grants are 00100 then 10000 with no gap besides the first-cycle slot, and `frame_done` at T+43. Sources 0, 1, and 3 are never requested.
- Mask 0 → `frame_done` at T+1 and `plot` never asserted.
- Tick while busy → pass unaffected, `frame_overrun`=1 held until reset.
- Assert `reset` at T+10 of a pass → `draw_req`=0 and `plot`=0 from T+11, no `frame_done`, all flags cleared.
- With `DRAW_SEQ_WATCHDOG_EN` and `TIMEOUT`=64, a source never asserts done → grant advances after 64 DRAW cycles and `timeout_err`=1. With the macro undefined, the grant remains and `timeout_err`=0.

Source files
------------

// File: rtl/draw_sequencer.sv
// Frame draw scheduler: grants sprite drawers one at a time in ascending index
// order and muxes the granted drawer's pixels onto the VGA port.
// Optional watchdog: define DRAW_SEQ_WATCHDOG_EN.
module draw_sequencer #(
  parameter int NUM_SRC = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_SRC-1:0]   src_enable,
  input  logic [NUM_SRC-1:0]   src_done,
  input  logic [8*NUM_SRC-1:0] src_x,
  input  logic [7*NUM_SRC-1:0] src_y,
  input  logic [3*NUM_SRC-1:0] src_colour,
  output logic [NUM_SRC-1:0]   draw_req,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_overrun,
  output logic                 timeout_err
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      cur_reg, cur_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic               first_reg, first_next;
  logic               overrun_reg;
  logic               done_hit, wd_fire, advance;
  logic               lo_found, up_found;
  logic [IW-1:0]      lo_idx, up_idx;

  logic [7:0] x_arr [NUM_SRC];
  logic [6:0] y_arr [NUM_SRC];
  logic [2:0] c_arr [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign x_arr[gi] = src_x[8*gi +: 8];
      assign y_arr[gi] = src_y[7*gi +: 7];
      assign c_arr[gi] = src_colour[3*gi +: 3];
    end
  endgenerate

  // Lowest set bit of the incoming enable, and lowest latched bit above cur.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    up_found = 1'b0;
    up_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_enable[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
      if (mask_reg[i] && (i > int'(cur_reg))) begin
        up_found = 1'b1;
        up_idx   = IW'(i);
      end
    end
  end

  // A done flag during the first grant cycle is left over from a previous pass.
  assign done_hit = (state_reg == DRAW) && !first_reg && src_done[cur_reg];
  assign advance  = done_hit || wd_fire;

`ifdef DRAW_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_reg;
  logic          timeout_reg;

  assign wd_fire     = (state_reg == DRAW) && !done_hit && (wd_reg == CW'(TIMEOUT - 1));
  assign timeout_err = timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_next == DRAW && first_next)
        wd_reg <= '0;
      else if (state_reg == DRAW)
        wd_reg <= wd_reg + 1'b1;
      if (wd_fire)
        timeout_reg <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    mask_next  = mask_reg;
    first_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          mask_next = src_enable;
          if (lo_found) begin
            cur_next   = lo_idx;
            first_next = 1'b1;
            state_next = DRAW;
          end else begin
            state_next = DONE;
          end
        end
      end
      DRAW: begin
        if (advance) begin
          if (up_found) begin
            cur_next   = up_idx;
            first_next = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      mask_reg    <= '0;
      first_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      mask_reg  <= mask_next;
      first_reg <= first_next;
      if (frame_tick && state_reg != IDLE)
        overrun_reg <= 1'b1;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign frame_done    = (state_reg == DONE);
  assign frame_overrun = overrun_reg;
  assign plot          = (state_reg == DRAW) && !first_reg && !wd_fire;
  assign draw_req      = (state_reg == DRAW) ? (NUM_SRC'(1) << cur_reg) : '0;
  assign vga_x         = plot ? x_arr[cur_reg] : 8'd0;
  assign vga_y         = plot ? y_arr[cur_reg] : 7'd0;
  assign vga_colour    = plot ? c_arr[cur_reg] : 3'd0;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized scoreboard bench for draw_sequencer with behavioural drawer models;
// honours DRAW_SEQ_WATCHDOG_EN when defined.
module tb_draw_sequencer;
  localparam int NS = 5;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_tick = 1'b0;
  logic [NS-1:0]   src_enable = '0;
  logic [NS-1:0]   src_done = '0;
  logic [8*NS-1:0] src_x = '0;
  logic [7*NS-1:0] src_y = '0;
  logic [3*NS-1:0] src_colour = '0;
  logic [NS-1:0]   draw_req;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            plot, busy, frame_done, frame_overrun, timeout_err;

  draw_sequencer #(.NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .src_enable(src_enable),
    .src_done(src_done), .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
    .draw_req(draw_req), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         cyc;
  } ev_t;

  ev_t           sb[$];
  int            checks = 0;
  int            errors = 0;
  int            len[NS];
  bit            sb_off = 1'b0;
  int            last_done_cyc = -1;
  int            tick_cyc = 0;
  logic [NS-1:0] cur_mask = '0;

  function automatic logic [7:0] px_x(int i, int j); return 8'(i * 40 + j); endfunction
  function automatic logic [6:0] px_y(int i, int j); return 7'(j * 3 + i); endfunction
  function automatic logic [2:0] px_c(int i, int j); return 3'(i + j + 1); endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sources drawn in ascending order, each costs its pixel count
  // plus one request slot; a drawer that never finishes is cut at TO cycles.
  function automatic void push_pass(int t_tick, logic [NS-1:0] m);
    int  t;
    ev_t e;
    t = t_tick + 1;
    for (int i = 0; i < NS; i++) begin
      if (m[i]) begin
        int npix = (len[i] == 0) ? TO - 2 : len[i];
        for (int j = 0; j < npix; j++) begin
          e.is_done = 1'b0; e.x = px_x(i, j); e.y = px_y(i, j); e.c = px_c(i, j);
          e.cyc = t + 1 + j;
          sb.push_back(e);
        end
        t += (len[i] == 0) ? TO : len[i] + 1;
      end
    end
    e.is_done = 1'b1; e.x = '0; e.y = '0; e.c = '0; e.cyc = t;
    sb.push_back(e);
  endfunction

  // Drawer models: registered outputs, done coincident with last pixel; len 0 never finishes.
  initial begin
    int            cnt[NS];
    logic [NS-1:0] req_s;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      req_s = draw_req;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (req_s[i] && (len[i] == 0 || cnt[i] < len[i])) begin
          src_x[8*i +: 8]      = px_x(i, cnt[i]);
          src_y[7*i +: 7]      = px_y(i, cnt[i]);
          src_colour[3*i +: 3] = px_c(i, cnt[i]);
          src_done[i]          = (len[i] != 0) && (cnt[i] == len[i] - 1);
          cnt[i]++;
        end else begin
          src_done[i] = 1'b0;
          if (!req_s[i]) cnt[i] = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a pixel or frame_done appears.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (plot && !sb_off) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_plot: got x=%0h y=%0h c=%0h, required no plot (cycle %0d)",
                   vga_x, vga_y, vga_colour, cyc);
        end else begin
          e = sb.pop_front();
          check("pix_x", 32'(vga_x), 32'(e.x));
          check("pix_y", 32'(vga_y), 32'(e.y));
          check("pix_c", 32'(vga_colour), 32'(e.c));
          check("pix_cycle", cyc, e.cyc);
        end
      end
      if (!plot) check("vga_zero", 32'({vga_x, vga_y, vga_colour}), 32'd0);
      if (frame_done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done: got frame_done=1, required 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
        end
        last_done_cyc = cyc;
      end
      check("req_in_mask", 32'(draw_req & ~cur_mask), 32'd0);
      check("req_onehot", 32'($countones(draw_req) <= 1), 32'd1);
    end
  end

  task automatic do_tick(logic [NS-1:0] m, bit push);
    @(posedge clk); #1;
    src_enable = m;
    frame_tick = 1'b1;
    tick_cyc   = cyc;
    if (push) begin
      cur_mask = m;
      push_pass(cyc, m);
    end
    @(posedge clk); #1;
    frame_tick = 1'b0;
    src_enable = NS'($urandom);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(busy == 1'b0 && sb.size() == 0) && n < 3000);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, required idle", name, busy, sb.size());
    end else begin
      $display("pass %s: frame_done at %0d, idle at %0d", name, last_done_cyc, cyc);
      check({name, "_busy_fall"}, cyc, last_done_cyc + 1);
    end
  endtask

  task automatic check_cleared(string name);
    check({name, "_req"}, 32'(draw_req), 32'd0);
    check({name, "_plot"}, 32'(plot), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(frame_done), 32'd0);
    check({name, "_overrun"}, 32'(frame_overrun), 32'd0);
    check({name, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < NS; i++) len[i] = 20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    check("reset_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    do_tick(5'b00001, 1'b1); wait_idle("single_src");
    do_tick(5'b10100, 1'b1); wait_idle("two_src");
    do_tick(5'b00000, 1'b1); wait_idle("empty_mask");

    check("overrun_pre", 32'(frame_overrun), 32'd0);
    for (int i = 0; i < NS; i++) len[i] = 6;
    do_tick(5'b00110, 1'b1);
    repeat (4) @(posedge clk);
    do_tick(5'b11111, 1'b0);
    wait_idle("overrun_pass");
    check("overrun_set", 32'(frame_overrun), 32'd1);
    do_tick(5'b00001, 1'b1); wait_idle("after_overrun");
    check("overrun_held", 32'(frame_overrun), 32'd1);

    for (int i = 0; i < NS; i++) len[i] = 20;
    do_tick(5'b00011, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_cleared("mid_reset");
    repeat (40) @(negedge clk);
    $display("pass mid_reset: reset at %0d, no frame_done", tick_cyc + 10);

    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < NS; i++) len[i] = $urandom_range(1, 12);
      do_tick(NS'($urandom_range(0, 31)), 1'b1);
      wait_idle("random");
    end

    len[2] = 0;
    len[3] = 4;
`ifdef DRAW_SEQ_WATCHDOG_EN
    do_tick(5'b01100, 1'b1);
    wait_idle("watchdog");
    check("timeout_err_set", 32'(timeout_err), 32'd1);
`else
    sb_off   = 1'b1;
    cur_mask = 5'b00100;
    do_tick(5'b00100, 1'b0);
    repeat (150) @(negedge clk);
    #2;
    check("hang_req", 32'(draw_req), 32'h4);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_plot", 32'(plot), 32'd1);
    check("hang_timeout_err", 32'(timeout_err), 32'd0);
    $display("pass no_watchdog: grant held at cycle %0d", cyc);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    sb_off = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
